// File: rtl/n64_pif_ram_dma_pkg.sv
// Shared definitions for the PIF RAM port-B block mover.
package n64_pif_ram_dma_pkg;

    localparam int PIF_RAM_AW      = 9;
    localparam int PIF_BLOCK_WORDS = 16;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } dma_state_e;

endpackage

// File: rtl/n64_pif_ram_dma_if.sv
// Control, PIF RAM port-B and stream signals of the block mover.
// The master modport is the mover itself; the slave modport is its surroundings.
interface n64_pif_ram_dma_if
    import n64_pif_ram_dma_pkg::*;
#(
    parameter int AW = PIF_RAM_AW
) ();

    logic          start;
    logic          dir;
    logic [AW-1:0] base_addr;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;

    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_ready;

    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;

    modport master (
        input  start, dir, base_addr, abort, ram_rdata, out_ready, in_valid, in_data,
        output busy, done, aborted, ram_addr, ram_wren, ram_wdata, out_valid, out_data, in_ready
    );

    modport slave (
        output start, dir, base_addr, abort, ram_rdata, out_ready, in_valid, in_data,
        input  busy, done, aborted, ram_addr, ram_wren, ram_wdata, out_valid, out_data, in_ready
    );

endinterface

// File: rtl/n64_pif_ram_dma_fifo2.sv
// Two-entry skid buffer that absorbs words already in flight from the
// registered RAM read when the outbound sink stalls.
module n64_pif_ram_dma_fifo2 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic [1:0]  count
);

    logic [31:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count_q;
    logic        do_pop;
    logic        do_push;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        head    = mem[rd_ptr];
        count   = count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/n64_pif_ram_dma.sv
// Port-B master of the PIF RAM: moves a WORDS-long block between the RAM
// and a valid/ready stream in either direction, one word per clock.
module n64_pif_ram_dma
    import n64_pif_ram_dma_pkg::*;
#(
    parameter int WORDS = PIF_BLOCK_WORDS,
    parameter int AW    = PIF_RAM_AW
) (
    input  logic               clk,
    input  logic               reset_n,
    n64_pif_ram_dma_if.master  bus
);

    localparam int            CW       = $clog2(WORDS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORDS);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    dma_state_e    state;
    dma_state_e    state_next;
    logic [AW-1:0] base_q;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] pop_cnt;
    logic [CW-1:0] wr_cnt;
    logic          rd_pending;
    logic          aborted_q;

    logic          issue;
    logic          pop;
    logic          push;
    logic          wr_fire;
    logic          abort_now;
    logic          xfer_start;
    logic          out_valid_int;
    logic [2:0]    occupancy;
    logic [1:0]    fifo_count;
    logic [31:0]   fifo_head;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A read is only issued if its data is guaranteed a FIFO slot one cycle later.
    always_comb begin
        state_next    = state;
        out_valid_int = (state == RD) && (fifo_count != 2'd0);
        pop           = out_valid_int && bus.out_ready;
        occupancy     = {1'b0, fifo_count} + {2'b0, rd_pending} - {2'b0, pop};
        issue         = (state == RD) && (issue_cnt < FULL_CNT) && (occupancy < 3'd2);
        push          = (state == RD) && rd_pending;
        wr_fire       = (state == WR) && (wr_cnt < FULL_CNT) && bus.in_valid;
        abort_now     = bus.abort && ((state == RD) || (state == WR));
        xfer_start    = (state == IDLE) && bus.start;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.dir == DIR_WRITE) ? WR : RD;
                end
            end
            RD: begin
                if (abort_now) begin
                    state_next = IDLE;
                end else if (pop && (pop_cnt == LAST_CNT)) begin
                    state_next = FIN;
                end
            end
            WR: begin
                if (abort_now) begin
                    state_next = IDLE;
                end else if (wr_fire && (wr_cnt == LAST_CNT)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        bus.busy      = (state != IDLE);
        bus.done      = (state == FIN);
        bus.aborted   = aborted_q;
        bus.in_ready  = (state == WR) && (wr_cnt < FULL_CNT);
        bus.out_valid = out_valid_int;
        bus.out_data  = out_valid_int ? fifo_head : '0;
        bus.ram_wren  = wr_fire;
        bus.ram_wdata = wr_fire ? bus.in_data : '0;
        if (issue) begin
            bus.ram_addr = base_q + AW'(issue_cnt);
        end else if (wr_fire) begin
            bus.ram_addr = base_q + AW'(wr_cnt);
        end else begin
            bus.ram_addr = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q     <= '0;
            issue_cnt  <= '0;
            pop_cnt    <= '0;
            wr_cnt     <= '0;
            rd_pending <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            aborted_q <= abort_now;
            if (xfer_start) begin
                base_q     <= bus.base_addr;
                issue_cnt  <= '0;
                pop_cnt    <= '0;
                wr_cnt     <= '0;
                rd_pending <= 1'b0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (pop) begin
                    pop_cnt <= pop_cnt + 1'b1;
                end
                if (wr_fire) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
                rd_pending <= issue && !abort_now;
            end
        end
    end

    n64_pif_ram_dma_fifo2 u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort_now),
        .push      (push),
        .push_data (bus.ram_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_n64_pif_ram_dma.sv
// Scoreboard bench for the PIF RAM block mover, with a behavioural 512x32
// RAM on port B (registered read, write on wren).
module tb_n64_pif_ram_dma;
    import n64_pif_ram_dma_pkg::*;

    localparam int WORDS = PIF_BLOCK_WORDS;
    localparam int AW    = PIF_RAM_AW;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    logic [31:0] exp_q [$];
    logic [40:0] wq    [$];
    logic [31:0] ram   [512];

    n64_pif_ram_dma_if #(.AW(AW)) bus ();

    n64_pif_ram_dma #(.WORDS(WORDS), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.dir       = DIR_READ;
        bus.base_addr = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
    endtask

    task automatic preload();
        for (int i = 0; i < 512; i++) begin
            ram[i] <= 32'hA500_0000 + 32'(i);
        end
        @(negedge clk);
    endtask

    task automatic start_xfer(input logic d, input logic [8:0] base);
        @(negedge clk);
        bus.dir       = d;
        bus.base_addr = base;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if ({bus.busy, bus.done, bus.aborted, bus.out_valid, bus.ram_wren, bus.in_ready,
             bus.ram_addr, bus.ram_wdata, bus.out_data} !== '0)
            $display("[TB] FAIL reset_outputs: busy=%b done=%b out_valid=%b wren=%b addr=%h, required all zero",
                     bus.busy, bus.done, bus.out_valid, bus.ram_wren, bus.ram_addr);
        if ({bus.busy, bus.done, bus.aborted, bus.out_valid, bus.ram_wren, bus.in_ready,
             bus.ram_addr, bus.ram_wdata, bus.out_data} !== '0)
            mismatched++;
        reset_n = 1'b1;
    endtask

    task automatic test_read_basic();
        int got = 0;
        logic [31:0] e;
        for (int k = 0; k < WORDS; k++) exp_q.push_back(32'hA500_0000 + 32'(k));
        bus.out_ready = 1'b1;
        start_xfer(DIR_READ, 9'h000);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            #1;
            if (cyc == 1 || cyc == 2) begin
                compared++;
                if (bus.ram_addr !== 9'(cyc - 1) || bus.ram_wren !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rd_issue_addr cycle %0d: addr=%h wren=%b, required addr=%h wren=0",
                             cyc, bus.ram_addr, bus.ram_wren, 9'(cyc - 1));
                end
            end
            if (bus.out_valid) begin
                compared++;
                if (cyc != 3 + got || exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL rd_timing: word %0d in cycle %0d, required cycle %0d", got, cyc, 3 + got);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    compared++;
                    if (bus.out_data !== e) begin
                        mismatched++;
                        $display("[TB] FAIL rd_data: got %h, required %h", bus.out_data, e);
                    end
                end
                got++;
            end
            compared++;
            if (bus.done !== (cyc == 19)) begin
                mismatched++;
                $display("[TB] FAIL rd_done cycle %0d: done=%b, required %b", cyc, bus.done, cyc == 19);
            end
            if (cyc == 20) begin
                compared++;
                if (bus.busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rd_busy_end: busy=%b, required 0", bus.busy);
                end
            end
            @(negedge clk);
        end
        compared++;
        if (got != WORDS) begin
            mismatched++;
            $display("[TB] FAIL rd_count: %0d words, required %0d", got, WORDS);
        end
        exp_q.delete();
        drive_idle();
    endtask

    task automatic test_read_backpressure();
        logic [8:0] base = 9'h1FC;
        logic [31:0] e;
        int got = 0;
        bit fin = 0;
        for (int k = 0; k < WORDS; k++) exp_q.push_back(32'hA500_0000 + 32'(9'(base + 9'(k))));
        start_xfer(DIR_READ, base);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            compared++;
            if (bus.ram_wren !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_wren: wren=%b in read, required 0", bus.ram_wren);
            end
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL bp_extra: extra word %h, required none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        mismatched++;
                        $display("[TB] FAIL bp_data: word %0d got %h, required %h", got, bus.out_data, e);
                    end
                end
                got++;
            end
            if (bus.done) begin
                fin = 1;
                compared++;
                if (bus.out_valid !== 1'b0 || got != WORDS) begin
                    mismatched++;
                    $display("[TB] FAIL bp_finish: out_valid=%b words=%0d, required 0 and %0d",
                             bus.out_valid, got, WORDS);
                end
            end
            @(negedge clk);
        end
        if (!fin) begin
            mismatched++;
            $display("[TB] FAIL bp_timeout: done not seen, words=%0d, required %0d", got, WORDS);
        end
        exp_q.delete();
        drive_idle();
    endtask

    task automatic run_write(input logic [8:0] base, input bit gaps, input logic [31:0] data0,
                             input string tag);
        int k = 0;
        bit fin = 0;
        logic exp_wren;
        logic [40:0] e;
        start_xfer(DIR_WRITE, base);
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            if (k < WORDS) begin
                bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data  = data0 + 32'(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (k == WORDS) begin
                fin = 1;
                compared++;
                if (bus.in_ready !== 1'b0 || bus.done !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL %s_finish: in_ready=%b done=%b, required 0 and 1",
                             tag, bus.in_ready, bus.done);
                end
            end else begin
                exp_wren = bus.in_valid;
                compared++;
                if (bus.ram_wren !== exp_wren || bus.done !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL %s_wren: word %0d wren=%b done=%b, required wren=%b done=0",
                             tag, k, bus.ram_wren, bus.done, exp_wren);
                end
                if (exp_wren) begin
                    compared++;
                    if (bus.ram_addr !== 9'(base + 9'(k)) || bus.ram_wdata !== data0 + 32'(k)) begin
                        mismatched++;
                        $display("[TB] FAIL %s_addr: addr=%h data=%h, required addr=%h data=%h", tag,
                                 bus.ram_addr, bus.ram_wdata, 9'(base + 9'(k)), data0 + 32'(k));
                    end
                    wq.push_back({9'(base + 9'(k)), data0 + 32'(k)});
                    k++;
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!fin) begin
            mismatched++;
            $display("[TB] FAIL %s_timeout: %0d words accepted, required %0d", tag, k, WORDS);
        end
        while (wq.size() != 0) begin
            e = wq.pop_front();
            compared++;
            if (ram[e[40:32]] !== e[31:0]) begin
                mismatched++;
                $display("[TB] FAIL %s_ram: ram[%h]=%h, required %h", tag, e[40:32], ram[e[40:32]], e[31:0]);
            end
        end
        drive_idle();
    endtask

    task automatic test_write_wrap();
        run_write(9'h1F8, 1'b0, 32'h0000_0100, "wr_wrap");
    endtask

    task automatic test_write_gaps();
        run_write(9'h080, 1'b1, 32'h0000_0300, "wr_gaps");
    endtask

    task automatic test_abort();
        int got = 0;
        bit hit = 0;
        logic [31:0] e;
        for (int k = 0; k < WORDS; k++) exp_q.push_back(32'hA500_0010 + 32'(k));
        bus.out_ready = 1'b1;
        start_xfer(DIR_READ, 9'h010);
        for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
            #1;
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                compared++;
                if (bus.out_data !== e) begin
                    mismatched++;
                    $display("[TB] FAIL ab_data: got %h, required %h", bus.out_data, e);
                end
                got++;
                if (got == 5) begin
                    bus.abort = 1'b1;
                    hit = 1;
                end
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
        #1;
        compared++;
        if (!hit || bus.busy !== 1'b0 || bus.aborted !== 1'b1 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ab_pulse: busy=%b aborted=%b done=%b out_valid=%b, required 0 1 0 0",
                     bus.busy, bus.aborted, bus.done, bus.out_valid);
        end
        @(negedge clk);
        #1;
        compared++;
        if (bus.aborted !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ab_once: aborted=%b done=%b, required 0 0", bus.aborted, bus.done);
        end
        exp_q.delete();
        drive_idle();
        run_write(9'h040, 1'b0, 32'h0000_0200, "ab_write");
    endtask

    task automatic test_start_while_busy();
        int got = 0;
        bit fin = 0;
        logic [31:0] e;
        for (int k = 0; k < WORDS; k++) exp_q.push_back(32'hA500_0020 + 32'(k));
        bus.out_ready = 1'b1;
        start_xfer(DIR_READ, 9'h020);
        for (int cyc = 1; cyc < 60 && !fin; cyc++) begin
            bus.start     = (cyc == 4);
            bus.dir       = (cyc == 4) ? DIR_WRITE : DIR_READ;
            bus.base_addr = (cyc == 4) ? 9'h100 : 9'h000;
            #1;
            compared++;
            if (bus.in_ready !== 1'b0 || bus.ram_wren !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL sb_dir: in_ready=%b wren=%b, required 0 0", bus.in_ready, bus.ram_wren);
            end
            if (bus.out_valid) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb_extra: extra word %h, required none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data !== e) begin
                        mismatched++;
                        $display("[TB] FAIL sb_data: got %h, required %h", bus.out_data, e);
                    end
                end
                got++;
            end
            if (bus.done) fin = 1;
            @(negedge clk);
        end
        bus.start = 1'b0;
        compared++;
        if (!fin || got != WORDS) begin
            mismatched++;
            $display("[TB] FAIL sb_finish: done_seen=%0d words=%0d, required 1 and %0d", fin, got, WORDS);
        end
        exp_q.delete();
        drive_idle();
    endtask

    task automatic test_reset_midread();
        bus.out_ready = 1'b1;
        start_xfer(DIR_READ, 9'h030);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        compared++;
        if ({bus.busy, bus.done, bus.aborted, bus.out_valid, bus.ram_wren, bus.in_ready,
             bus.ram_addr, bus.ram_wdata, bus.out_data} !== '0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: busy=%b out_valid=%b data=%h addr=%h, required all zero",
                     bus.busy, bus.out_valid, bus.out_data, bus.ram_addr);
        end
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            #1;
            compared++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.out_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_reset_quiet: busy=%b done=%b aborted=%b out_valid=%b, required 0",
                         bus.busy, bus.done, bus.aborted, bus.out_valid);
            end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        preload();
        test_reset();
        test_read_basic();
        test_read_backpressure();
        test_write_wrap();
        test_write_gaps();
        test_abort();
        test_start_while_busy();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/n64_pif_ram_dma.md
Name: n64_pif_ram_dma

Overview:
- Single-clock block mastering the 32-bit word port (port B) of the 512x32 PIF RAM.
- Moves a fixed-length block of words in either direction:
  - Read: PIF RAM to an outbound valid/ready stream.
  - Write: an inbound valid/ready stream into PIF RAM.
- Sits between the PIF RAM and the SI/RDRAM-side DMA logic; it is the PIF RAM's port-B producer and consumer.
- Read path is pipelined against the RAM's 1-cycle registered read, so steady-state throughput is 1 word/clock.

Parameters:
- WORDS, 16, words per transfer (64-byte PIF block); legal range 1..512.
- AW, 9, PIF RAM word-address width.

Ports:
- clk  in  1  block clock; same clock as PIF RAM clkb.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin transfer; sampled only in IDLE.
- dir  in  1  0 = PIF RAM to out stream (read), 1 = in stream to PIF RAM (write); sampled with start.
- base_addr  in  AW  first word address; sampled with start.
- abort  in  1  cancel the current transfer.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.
- ram_addr  out  AW  to PIF RAM address_b.
- ram_wren  out  1  to PIF RAM wren_b.
- ram_wdata  out  32  to PIF RAM data_b.
- ram_rdata  in  32  from PIF RAM q_b; valid the cycle after the address is presented.
- out_valid  out  1  outbound word valid.
- out_data  out  32  outbound word.
- out_ready  in  1  outbound sink ready.
- in_valid  in  1  inbound word valid.
- in_data  in  32  inbound word.
- in_ready  out  1  block accepts inbound word.

Behaviour:
- Reset (reset_n low at an edge):
  - State goes to IDLE; all counters clear; FIFO empties; rd_pending clears.
  - All outputs 0, including ram_addr.
  - Reset mid-transfer drops all data with no done or aborted pulse.
- States: IDLE, RD, WR, FIN.
  - IDLE to RD or WR when start=1, per dir. base_addr is latched at the same edge.
  - start while busy is ignored.
- Address rule: word k uses (base + k) mod 512. The 9-bit pointer wraps 511 to 0.
- RD state:
  - issue_cnt counts words issued; a read is issued combinationally when issue_cnt < WORDS and fifo_count + rd_pending - pop < 2.
  - pop = out_valid & out_ready.
  - On issue: ram_addr = base + issue_cnt, ram_wren = 0, and rd_pending is set for the next cycle.
  - In the cycle after an issue, ram_rdata is pushed into the 2-entry FIFO at the end of that cycle.
  - out_valid = FIFO not empty; out_data = FIFO head.
  - Data must not be lost or duplicated under any out_ready pattern.
  - RD to FIN at the edge where the WORDS-th pop occurs.
- RD latency: start sampled at edge of cycle 0 gives ram_addr = base in cycle 1 and first out_valid in cycle 3. With out_ready held at 1, words appear in cycles 3..WORDS+2.
- WR state:
  - in_ready = 1 while wr_cnt < WORDS.
  - On in_valid & in_ready in the same cycle: ram_wren = 1, ram_addr = base + wr_cnt, ram_wdata = in_data. All are combinational and committed by the RAM at that edge.
  - WR to FIN at the edge accepting the WORDS-th word; in_ready is 0 from the next cycle.
- FIN: done = 1 for exactly one cycle, busy still 1; then go to IDLE.
- Abort:
  - abort=1 in RD or WR goes to IDLE at that edge; aborted pulses the next cycle and done does not pulse.
  - FIFO and rd_pending flush at that edge.
  - A write handshake in the abort cycle still commits.
  - An out handshake in the abort cycle counts as delivered.
  - abort in IDLE or FIN is ignored. abort has priority over completion in the same cycle.
- ram_wren is never 1 in RD, IDLE or FIN. out_valid is never 1 outside RD.

Decomposition:
- Shared package n64_pif_ram_dma_pkg:
  - state enum (IDLE/RD/WR/FIN).
  - DIR_READ = 0, DIR_WRITE = 1.
  - PIF_RAM_AW = 9.
  - PIF_BLOCK_WORDS = 16.
- One sub-module, n64_pif_ram_dma_fifo2: 2-entry, 32-bit FIFO with push/pop/count, synchronous active-low reset, plus synchronous flush. It holds the read-latency skid buffer.

Test Plan:
- Read, base=0x000, RAM preloaded with word i = 0xA5000000+i, out_ready=1:
  - ram_addr=0 in cycle 1.
  - out_data 0xA5000000..0xA500000F in cycles 3..18.
  - done in cycle 19; busy low in cycle 20.
- Read with out_ready toggling 1,0,0,1 pseudo-randomly: all 16 words delivered in order, no duplicates, FIFO never overflows, ram_wren stays 0.
- Write, base=0x1F8, in_valid=1, in_data=0x100+k:
  - RAM words 0x1F8..0x1FF and 0x000..0x007 hold 0x100..0x10F (wrap).
  - in_ready drops after the 16th accept; done one cycle later.
- Write with in_valid gaps: ram_wren fires only on handshake cycles; count and addresses stay contiguous.
- abort at the 5th read handshake:
  - State is IDLE next edge; aborted pulses once, no done.
  - A subsequent start with dir=1 runs a clean write.
- start pulsed during busy: ignored, no change of base/dir. reset_n low mid-read clears all outputs to 0 the next cycle.
